ysyx_22040895_wbu: RTL and testbench

Write-back unit sitting directly upstream of the general-purpose register file's write port. It merges results from the single-cycle execute unit (EXU) and the multi-cycle load/store unit (LSU) into one registered write (`we_o`/`waddr_o`/`wdata_o`) toward the register file. A per-register pending scoreboard lets decode stall on RAW/WAW hazards until the write has landed in the register file.

---
 rtl/ysyx_22040895_wbu_pkg.sv | 18 +
 rtl/ysyx_22040895_wbu_scoreboard.sv | 69 ++++++
 rtl/ysyx_22040895_wbu.sv | 102 ++++++++++
 tb/tb_ysyx_22040895_wbu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_wbu_pkg.sv
// Shared widths and write-back source encodings for the write-back unit.
package ysyx_22040895_wbu_pkg;

    localparam int ysyx_22040895_RegBus     = 64;
    localparam int ysyx_22040895_RegAddrBus = 5;
    localparam int ysyx_22040895_RegNum     = 32;

    localparam logic ysyx_22040895_WriteEnable = 1'b1;

    typedef enum logic {
        WB_SRC_EXU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    localparam wb_src_e ysyx_22040895_WbSrcLsu = WB_SRC_LSU;
    localparam wb_src_e ysyx_22040895_WbSrcExu = WB_SRC_EXU;

endpackage

// File: rtl/ysyx_22040895_wbu_scoreboard.sv
// Per-register pending scoreboard: tracks in-flight writes, raises the
// RAW/WAW hazard stall toward decode and flags results nobody was waiting for.
module ysyx_22040895_scoreboard
    import ysyx_22040895_wbu_pkg::*;
#(
    parameter int ADDR_W = ysyx_22040895_RegAddrBus
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid_i,
    input  logic                            issue_we_i,
    input  logic [ADDR_W-1:0]               issue_rd_i,
    input  logic                            issue_rs1_en_i,
    input  logic [ADDR_W-1:0]               issue_rs1_i,
    input  logic                            issue_rs2_en_i,
    input  logic [ADDR_W-1:0]               issue_rs2_i,
    input  logic                            clr_en_i,
    input  logic [ADDR_W-1:0]               clr_addr_i,
    input  logic                            acc_valid_i,
    input  logic [ADDR_W-1:0]               acc_rd_i,
    output logic                            stall_o,
    output logic [ysyx_22040895_RegNum-1:0] pending_o,
    output logic                            err_o
);

    logic [ysyx_22040895_RegNum-1:0] pending_q, pending_d;
    logic                            err_q, err_d;
    logic                            issue_fire;

    // Hazard compare: any used source or the destination still in flight.
    always_comb begin
        stall_o = issue_valid_i &&
                  ((issue_rs1_en_i && pending_q[issue_rs1_i]) ||
                   (issue_rs2_en_i && pending_q[issue_rs2_i]) ||
                   (issue_we_i     && pending_q[issue_rd_i]));
        issue_fire = issue_valid_i && !stall_o;
    end

    // Next scoreboard state; set is applied after clear so set wins on a collision.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        if (clr_en_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (issue_fire && issue_we_i && (issue_rd_i != '0)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
        if (acc_valid_i && (acc_rd_i != '0) && !pending_q[acc_rd_i]) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending_o = pending_q;
    assign err_o     = err_q;

endmodule

// File: rtl/ysyx_22040895_wbu.sv
// Write-back unit: LSU-priority arbiter between EXU and LSU results feeding
// one registered register-file write port, plus the hazard scoreboard.
module ysyx_22040895_wbu
    import ysyx_22040895_wbu_pkg::*;
#(
    parameter int REG_W  = ysyx_22040895_RegBus,
    parameter int ADDR_W = ysyx_22040895_RegAddrBus
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid_i,
    input  logic                            issue_we_i,
    input  logic [ADDR_W-1:0]               issue_rd_i,
    input  logic                            issue_rs1_en_i,
    input  logic                            issue_rs2_en_i,
    input  logic [ADDR_W-1:0]               issue_rs1_i,
    input  logic [ADDR_W-1:0]               issue_rs2_i,
    output logic                            stall_o,
    input  logic                            exu_valid_i,
    output logic                            exu_ready_o,
    input  logic [ADDR_W-1:0]               exu_rd_i,
    input  logic [REG_W-1:0]                exu_data_i,
    input  logic                            lsu_valid_i,
    output logic                            lsu_ready_o,
    input  logic [ADDR_W-1:0]               lsu_rd_i,
    input  logic [REG_W-1:0]                lsu_data_i,
    output logic                            we_o,
    output logic [ADDR_W-1:0]               waddr_o,
    output logic [REG_W-1:0]                wdata_o,
    output logic [ysyx_22040895_RegNum-1:0] pending_o,
    output logic                            err_o
);

    wb_src_e           src_sel;
    logic              acc_valid;
    logic [ADDR_W-1:0] acc_rd;
    logic [REG_W-1:0]  acc_data;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [REG_W-1:0]  wdata_q, wdata_d;

    // Fixed-priority arbitration: LSU always wins; nothing is accepted in reset.
    always_comb begin
        lsu_ready_o = rst;
        exu_ready_o = rst && !lsu_valid_i;
        src_sel     = lsu_valid_i ? ysyx_22040895_WbSrcLsu : ysyx_22040895_WbSrcExu;
        acc_valid   = (lsu_valid_i && lsu_ready_o) || (exu_valid_i && exu_ready_o);
        acc_rd      = (src_sel == WB_SRC_LSU) ? lsu_rd_i   : exu_rd_i;
        acc_data    = (src_sel == WB_SRC_LSU) ? lsu_data_i : exu_data_i;
    end

    // Next write-port contents; x0 results are accepted but dropped.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (acc_valid && (acc_rd != '0)) begin
            we_d    = ysyx_22040895_WriteEnable;
            waddr_d = acc_rd;
            wdata_d = acc_data;
        end
    end

    // Registered write port toward the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    ysyx_22040895_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .issue_valid_i  (issue_valid_i),
        .issue_we_i     (issue_we_i),
        .issue_rd_i     (issue_rd_i),
        .issue_rs1_en_i (issue_rs1_en_i),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_en_i (issue_rs2_en_i),
        .issue_rs2_i    (issue_rs2_i),
        .clr_en_i       (we_q),
        .clr_addr_i     (waddr_q),
        .acc_valid_i    (acc_valid),
        .acc_rd_i       (acc_rd),
        .stall_o        (stall_o),
        .pending_o      (pending_o),
        .err_o          (err_o)
    );

endmodule

// File: tb/tb_ysyx_22040895_wbu.sv
module tb_ysyx_22040895_wbu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid_i = 0, issue_we_i = 0, issue_rs1_en_i = 0, issue_rs2_en_i = 0;
    logic [4:0]  issue_rd_i = 0, issue_rs1_i = 0, issue_rs2_i = 0;
    logic        stall_o;
    logic        exu_valid_i = 0, exu_ready_o;
    logic [4:0]  exu_rd_i = 0;
    logic [63:0] exu_data_i = 0;
    logic        lsu_valid_i = 0, lsu_ready_o;
    logic [4:0]  lsu_rd_i = 0;
    logic [63:0] lsu_data_i = 0;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic [31:0] pending_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: set of registers with an outstanding write,
    // plus the write the register file should see this cycle.
    bit          m_pend [32];
    bit          m_we;
    bit   [4:0]  m_waddr;
    bit   [63:0] m_wdata;
    bit          m_err;
    bit          m_exu_taken;

    ysyx_22040895_wbu #(.REG_W(64), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_rd_i(issue_rd_i),
        .issue_rs1_en_i(issue_rs1_en_i), .issue_rs2_en_i(issue_rs2_en_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .stall_o(stall_o),
        .exu_valid_i(exu_valid_i), .exu_ready_o(exu_ready_o), .exu_rd_i(exu_rd_i), .exu_data_i(exu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .pending_o(pending_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".we"},      we_o,      m_we);
        chk({tag, ".waddr"},   waddr_o,   m_waddr);
        chk({tag, ".wdata"},   wdata_o,   m_wdata);
        chk({tag, ".pending"}, pending_o, pend_vec());
        chk({tag, ".err"},     err_o,     m_err);
    endtask

    task automatic idle();
        issue_valid_i = 0; issue_we_i = 0; issue_rs1_en_i = 0; issue_rs2_en_i = 0;
        exu_valid_i = 0; lsu_valid_i = 0;
    endtask

    task automatic issue(input bit we, input int rd, input bit e1, input int r1, input bit e2, input int r2);
        issue_valid_i = 1; issue_we_i = we; issue_rd_i = rd[4:0];
        issue_rs1_en_i = e1; issue_rs1_i = r1[4:0]; issue_rs2_en_i = e2; issue_rs2_i = r2[4:0];
    endtask

    // One clock: check combinational outputs, advance model across the edge,
    // then check registered outputs half a cycle later.
    task automatic tick(input string tag);
        bit          exp_stall, acc, lsu_win;
        bit   [4:0]  a_rd;
        bit   [63:0] a_data;
        bit          n_pend [32];
        #1;
        exp_stall = issue_valid_i && ((issue_rs1_en_i && m_pend[issue_rs1_i]) ||
                                      (issue_rs2_en_i && m_pend[issue_rs2_i]) ||
                                      (issue_we_i && m_pend[issue_rd_i]));
        chk({tag, ".stall"},     stall_o,     exp_stall);
        chk({tag, ".lsu_ready"}, lsu_ready_o, 1'b1);
        chk({tag, ".exu_ready"}, exu_ready_o, !lsu_valid_i);
        lsu_win = lsu_valid_i;
        acc     = lsu_valid_i || exu_valid_i;
        a_rd    = lsu_win ? lsu_rd_i : exu_rd_i;
        a_data  = lsu_win ? lsu_data_i : exu_data_i;
        m_exu_taken = exu_valid_i && !lsu_valid_i;
        n_pend = m_pend;
        if (m_we) n_pend[m_waddr] = 0;
        if (issue_valid_i && !exp_stall && issue_we_i && issue_rd_i != 0) n_pend[issue_rd_i] = 1;
        if (acc && a_rd != 0 && !m_pend[a_rd]) m_err = 1;
        @(posedge clk);
        m_pend = n_pend;
        m_we   = acc && a_rd != 0;
        if (m_we) begin
            m_waddr = a_rd;
            m_wdata = a_data;
        end
        @(negedge clk);
        chk_regs(tag);
    endtask

    initial begin
        model_reset();
        idle();
        #3;
        chk("rst.we", we_o, 1'b0);
        chk("rst.pending", pending_o, 32'h0);
        chk("rst.exu_ready", exu_ready_o, 1'b0);
        chk("rst.lsu_ready", lsu_ready_o, 1'b0);
        chk("rst.stall", stall_o, 1'b0);
        @(negedge clk);
        rst = 1;
        tick("idle0");
        tick("idle1");

        // Issue rd=5, then RAW/WAW stalls, then EXU delivers.
        issue(1, 5, 0, 0, 0, 0); tick("iss5");
        chk("iss5.bit", pending_o[5], 1'b1);
        issue(1, 5, 0, 0, 0, 0); tick("waw5");
        issue(0, 0, 1, 5, 0, 0); tick("raw5a");
        issue(0, 0, 1, 5, 0, 0);
        exu_valid_i = 1; exu_rd_i = 5; exu_data_i = 64'hDEAD_BEEF; tick("exu5");
        chk("exu5.wdata_lit", wdata_o, 64'hDEAD_BEEF);
        exu_valid_i = 0;
        issue(0, 0, 1, 5, 0, 0); tick("raw5b");
        chk("raw5b.bit", pending_o[5], 1'b0);
        issue(0, 0, 0, 0, 1, 5); tick("raw5c");
        idle();

        // EXU and LSU simultaneously.
        issue(1, 3, 0, 0, 0, 0); tick("iss3");
        issue(1, 4, 0, 0, 0, 0); tick("iss4");
        idle();
        exu_valid_i = 1; exu_rd_i = 3; exu_data_i = 64'h11;
        lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 64'h22;
        tick("both");
        chk("both.waddr_lit", waddr_o, 5'd4);
        lsu_valid_i = 0; tick("exu_after");
        chk("exu_after.wdata_lit", wdata_o, 64'h11);
        exu_valid_i = 0; tick("drain");

        // x0 destination and result.
        issue(1, 0, 0, 0, 0, 0); tick("iss0");
        idle(); exu_valid_i = 1; exu_rd_i = 0; exu_data_i = 64'h99; tick("res0");
        exu_valid_i = 0; tick("res0b");

        // Unexpected result sets sticky error.
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 64'h77; tick("err7");
        chk("err7.err_lit", err_o, 1'b1);
        lsu_valid_i = 0; tick("err7b"); tick("err7c");

        // Async reset while a write is on the port.
        issue(1, 9, 0, 0, 0, 0); tick("iss9");
        idle(); exu_valid_i = 1; exu_rd_i = 9; exu_data_i = 64'h1234; tick("exu9");
        chk("exu9.we_lit", we_o, 1'b1);
        exu_valid_i = 0;
        #2 rst = 0;
        #1;
        model_reset();
        chk("arst.we", we_o, 1'b0);
        chk("arst.pending", pending_o, 32'h0);
        chk("arst.err", err_o, 1'b0);
        chk("arst.exu_ready", exu_ready_o, 1'b0);
        @(negedge clk);
        rst = 1;
        tick("post_rst");

        // Randomized traffic: mostly results for registers actually in flight.
        for (int c = 0; c < 400; c++) begin
            issue_valid_i  = ($urandom_range(1, 0) == 1);
            issue_we_i     = ($urandom_range(3, 0) != 0);
            issue_rd_i     = 5'($urandom_range(31, 0));
            issue_rs1_en_i = $urandom_range(1, 0);
            issue_rs1_i    = 5'($urandom_range(31, 0));
            issue_rs2_en_i = $urandom_range(1, 0);
            issue_rs2_i    = 5'($urandom_range(31, 0));
            if (!exu_valid_i || m_exu_taken) begin
                exu_valid_i = ($urandom_range(2, 0) == 0);
                exu_rd_i    = 5'($urandom_range(31, 0));
                for (int k = 0; k < 8 && $urandom_range(9, 0) != 0; k++)
                    if (!m_pend[exu_rd_i]) exu_rd_i = 5'($urandom_range(31, 0));
                exu_data_i  = {$urandom, $urandom};
            end
            lsu_valid_i = ($urandom_range(3, 0) == 0);
            lsu_rd_i    = 5'($urandom_range(31, 0));
            for (int k = 0; k < 8 && $urandom_range(9, 0) != 0; k++)
                if (!m_pend[lsu_rd_i]) lsu_rd_i = 5'($urandom_range(31, 0));
            lsu_data_i  = {$urandom, $urandom};
            tick("rand");
        end
        idle();
        tick("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
